gmii_to_axi: RTL

// - Receive-path counterpart of the 64b-AXIS-to-GMII transmit path.
// - Accepts the 8-bit GMII receive stream, strips preamble/SFD, and packs bytes little-endian into 64-bit AXI-Stream beats with tkeep/tlast.
// - Runs entirely in the gmii_rx_clk domain (125 MHz). Any CDC to the 156.25 MHz MAC clock is done downstream by an async FIFO.

---
 rtl/gmii_to_axi_if.sv | 12 +
 rtl/gmii_to_axi.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/gmii_to_axi_if.sv
// AXI-Stream byte-packed receive bus between the GMII deframer and its sink.
interface gmii_to_axi_if;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/gmii_to_axi.sv
// GMII receive deframer: strips preamble/SFD and packs bytes little-endian
// into 64-bit AXI-Stream beats. One clock domain (gmii_rx_clk).
module gmii_to_axi #(
    parameter bit STRIP_PREAMBLE  = 1'b1,
    parameter int MAX_FRAME_BYTES = 1536
) (
    input  logic          gmii_rx_clk,
    input  logic          rst,
    input  logic          gmii_rx_dv,
    input  logic [7:0]    gmii_rxd,
    input  logic          gmii_rx_er,
    gmii_to_axi_if.master axis,
    output logic [15:0]   drop_cnt
);
    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    localparam logic [10:0] MAX_B    = 11'(MAX_FRAME_BYTES);
    localparam logic [7:0]  PREAMBLE = 8'h55;
    localparam logic [7:0]  SFD      = 8'hD5;

    state_t          state;
    logic [7:0][7:0] acc;        // lane i holds byte i of the beat being built
    logic [3:0]      acc_cnt;    // 8 means a full beat is held waiting for lookahead
    logic [10:0]     byte_cnt;   // data bytes accepted in this frame
    logic            bad;        // sticky rx_er seen in this frame
    logic            term_pend;  // a partial frame downstream still needs closing
    logic            beat_sent;  // this frame has pushed at least one beat
    logic            dv_q;       // previous dv, used to find the rising edge
    logic            out_free;

    // The output register can take a new beat this edge.
    assign out_free = !axis.tvalid || axis.tready;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Deframer FSM, beat accumulator and output register.
    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            acc_cnt     <= '0;
            byte_cnt    <= '0;
            bad         <= 1'b0;
            term_pend   <= 1'b0;
            beat_sent   <= 1'b0;
            // Starts high so a frame already in flight at release is not
            // mistaken for a fresh dv rise.
            dv_q        <= 1'b1;
            drop_cnt    <= '0;
            axis.tvalid <= 1'b0;
            axis.tdata  <= '0;
            axis.tkeep  <= '0;
            axis.tlast  <= 1'b0;
            axis.tuser  <= 1'b0;
        end else begin
            dv_q <= gmii_rx_dv;
            if (axis.tvalid && axis.tready)
                axis.tvalid <= 1'b0;

            case (state)
                IDLE: begin
                    // Close an aborted frame once dv is low and the slot is free.
                    if (term_pend && out_free) begin
                        axis.tvalid <= 1'b1;
                        axis.tdata  <= '0;
                        axis.tkeep  <= 8'h01;
                        axis.tlast  <= 1'b1;
                        axis.tuser  <= 1'b1;
                        term_pend   <= 1'b0;
                    end
                    if (gmii_rx_dv && !dv_q) begin
                        if (term_pend) begin
                            state    <= DROP;
                            drop_cnt <= sat_inc(drop_cnt);
                        end else begin
                            bad       <= 1'b0;
                            beat_sent <= 1'b0;
                            acc_cnt   <= '0;
                            byte_cnt  <= '0;
                            if (STRIP_PREAMBLE) begin
                                state <= PRE;
                            end else begin
                                state    <= DATA;
                                acc[0]   <= gmii_rxd;
                                acc_cnt  <= 4'd1;
                                byte_cnt <= 11'd1;
                                bad      <= gmii_rx_er;
                            end
                        end
                    end
                end

                PRE: begin
                    if (!gmii_rx_dv)
                        state <= IDLE;
                    else if (gmii_rxd == SFD)
                        state <= DATA;
                    else if (gmii_rxd != PREAMBLE)
                        state <= DROP;
                end

                DATA: begin
                    if (gmii_rx_dv && byte_cnt != MAX_B && (acc_cnt != 4'd8 || out_free)) begin
                        byte_cnt <= byte_cnt + 11'd1;
                        if (gmii_rx_er)
                            bad <= 1'b1;
                        if (acc_cnt == 4'd8) begin
                            // More data follows, so the held beat is not last.
                            axis.tvalid <= 1'b1;
                            axis.tdata  <= acc;
                            axis.tkeep  <= 8'hFF;
                            axis.tlast  <= 1'b0;
                            axis.tuser  <= 1'b0;
                            beat_sent   <= 1'b1;
                            acc[0]      <= gmii_rxd;
                            acc_cnt     <= 4'd1;
                        end else begin
                            acc[acc_cnt[2:0]] <= gmii_rxd;
                            acc_cnt           <= acc_cnt + 4'd1;
                        end
                    end else if (!gmii_rx_dv && acc_cnt == 4'd0) begin
                        // SFD followed directly by end of frame: nothing to send.
                        state    <= IDLE;
                        drop_cnt <= sat_inc(drop_cnt);
                    end else if (!gmii_rx_dv && out_free) begin
                        axis.tvalid <= 1'b1;
                        axis.tdata  <= acc;
                        axis.tkeep  <= 8'((9'd1 << acc_cnt) - 9'd1);
                        axis.tlast  <= 1'b1;
                        axis.tuser  <= bad;
                        acc_cnt     <= '0;
                        state       <= IDLE;
                    end else begin
                        // Oversize or output overflow: abandon the frame.
                        state     <= gmii_rx_dv ? DROP : IDLE;
                        acc_cnt   <= '0;
                        term_pend <= beat_sent;
                        drop_cnt  <= sat_inc(drop_cnt);
                    end
                end

                DROP: begin
                    if (!gmii_rx_dv)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
